// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction register / control FSM slice:
// state names, opcode fields, writeback selects and the instruction classifier.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_GET_A     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_EXEC      = 3'd4,
    ST_WRITE_REG = 3'd5,
    ST_WRITE_IMM = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    INS_ILLEGAL = 3'd0,
    INS_MOV_IMM = 3'd1,
    INS_MOV_REG = 3'd2,
    INS_ADD     = 3'd3,
    INS_CMP     = 3'd4,
    INS_AND     = 3'd5,
    INS_MVN     = 3'd6
  } ins_t;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;

  function automatic ins_t classify(input logic [2:0] opcode, input logic [1:0] op);
    ins_t ins;
    ins = INS_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)
        ins = INS_MOV_IMM;
      else if (op == OP_MOV_REG)
        ins = INS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  ins = INS_ADD;
        OP_CMP:  ins = INS_CMP;
        OP_AND:  ins = INS_AND;
        default: ins = INS_MVN;
      endcase
    end
    return ins;
  endfunction

  // Every instruction that goes through the shifter/ALU path (all but MOV imm).
  function automatic logic uses_shifter(input ins_t ins);
    return (ins == INS_MOV_REG) || (ins == INS_ADD) || (ins == INS_CMP) ||
           (ins == INS_AND) || (ins == INS_MVN);
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Instruction/handshake inputs and datapath control outputs of cpu_ctrl.
// master = the driver of instructions (top level / bench), slave = cpu_ctrl.
interface cpu_ctrl_if;

  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  modport master (
    output in, load, s,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
    input  asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    input  in, load, s,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
    output asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );

endinterface

// File: rtl/instr_dec.sv
// Combinational field extraction, instruction classification and
// immediate sign extension from the instruction register.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output ins_t        ins
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign ins    = classify(ir[15:13], ir[12:11]);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sext
      if (gi < 8) begin : g_imm8_lo
        assign sximm8[gi] = ir[gi];
      end else begin : g_imm8_hi
        assign sximm8[gi] = ir[7];
      end
      if (gi < 5) begin : g_imm5_lo
        assign sximm5[gi] = ir[gi];
      end else begin : g_imm5_hi
        assign sximm5[gi] = ir[4];
      end
    end
  endgenerate

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register plus the multi-cycle control FSM that sequences
// register-file reads/writes and datapath load strobes for one instruction.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  cpu_ctrl_if.slave  bus
);

  logic [15:0] ir_reg;
  state_t      state_reg;
  state_t      state_next;

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [1:0]  sh;
  logic [2:0]  rm;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  ins_t        ins;

  instr_dec u_dec (
    .ir     (ir_reg),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8),
    .sximm5 (sximm5),
    .ins    (ins)
  );

  // IR only accepts a new word while idle, so a running instruction is stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ir_reg <= '0;
    else if (state_reg == ST_WAIT && bus.load)
      ir_reg <= bus.in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= ST_WAIT;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT: begin
        if (bus.s)
          state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (ins)
          INS_MOV_IMM:          state_next = ST_WRITE_IMM;
          INS_MOV_REG, INS_MVN: state_next = ST_GET_B;
          INS_ADD, INS_CMP,
          INS_AND:              state_next = ST_GET_A;
          default:              state_next = ST_WAIT;
        endcase
      end
      ST_GET_A:     state_next = ST_GET_B;
      ST_GET_B:     state_next = ST_EXEC;
      ST_EXEC:      state_next = (ins == INS_CMP) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_next = ST_WAIT;
      ST_WRITE_IMM: state_next = ST_WAIT;
      default:      state_next = ST_WAIT;
    endcase
  end

  // Moore outputs; shift/ALUop follow the IR so they settle before EXEC.
  always_comb begin
    bus.w        = 1'b0;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.write    = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.vsel     = VSEL_C;
    bus.shift    = uses_shifter(ins) ? sh : 2'b00;
    bus.ALUop    = (opcode == OPC_ALU) ? op : 2'b00;
    case (state_reg)
      ST_WAIT: begin
        bus.w = 1'b1;
      end
      ST_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      ST_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      ST_EXEC: begin
        bus.loadc = 1'b1;
        bus.loads = (ins == INS_CMP);
        bus.asel  = (ins == INS_MOV_REG) || (ins == INS_MVN);
      end
      ST_WRITE_REG: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
        bus.vsel     = VSEL_C;
      end
      ST_WRITE_IMM: begin
        bus.writenum = rn;
        bus.write    = 1'b1;
        bus.vsel     = VSEL_IMM8;
      end
      default: begin
      end
    endcase
  end

  assign bus.sximm8 = sximm8;
  assign bus.sximm5 = sximm5;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: an instruction-level schedule model checked every
// cycle, plus hand-computed expectations for the listed instruction words.
module tb_cpu_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_ctrl_if bus ();

  cpu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- instruction-level model ----------------
  localparam int S_WAIT = 0, S_DEC = 1, S_A = 2, S_B = 3, S_X = 4, S_WR = 5, S_WI = 6;
  localparam int K_ILL = 0, K_MOVI = 1, K_MOVR = 2, K_ADD = 3, K_CMP = 4, K_AND = 5, K_MVN = 6;

  function automatic int kind(input logic [15:0] ir);
    case ({ir[15:13], ir[12:11]})
      5'b110_10: return K_MOVI;
      5'b110_00: return K_MOVR;
      5'b101_00: return K_ADD;
      5'b101_01: return K_CMP;
      5'b101_10: return K_AND;
      5'b101_11: return K_MVN;
      default:   return K_ILL;
    endcase
  endfunction

  // Busy-cycle schedule of each instruction, as a list of steps.
  function automatic int plan_len(input logic [15:0] ir);
    case (kind(ir))
      K_MOVI:         return 2;
      K_MOVR, K_MVN:  return 4;
      K_ADD, K_AND:   return 5;
      K_CMP:          return 4;
      default:        return 1;
    endcase
  endfunction

  function automatic int plan_step(input logic [15:0] ir, input int i);
    int k = kind(ir);
    if (i == 0) return S_DEC;
    if (k == K_MOVI) return S_WI;
    if (k == K_MOVR || k == K_MVN) begin
      if (i == 1) return S_B;
      if (i == 2) return S_X;
      return S_WR;
    end
    if (i == 1) return S_A;
    if (i == 2) return S_B;
    if (i == 3) return S_X;
    return S_WR;
  endfunction

  function automatic logic [51:0] exp_vec(input int step, input logic [15:0] ir);
    int         k  = kind(ir);
    logic [2:0] rn = ir[10:8];
    logic [2:0] rd = ir[7:5];
    logic [2:0] rm = ir[2:0];
    logic [2:0] rdn;
    logic [2:0] wrn;
    logic [1:0] shf;
    logic [1:0] alu;
    rdn = (step == S_A) ? rn : (step == S_B) ? rm : 3'd0;
    wrn = (step == S_WR) ? rd : (step == S_WI) ? rn : 3'd0;
    shf = (k != K_ILL && k != K_MOVI) ? ir[4:3] : 2'b00;
    alu = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
    return {step == S_WAIT, rdn, wrn, (step == S_WR || step == S_WI),
            step == S_A, step == S_B, step == S_X, (step == S_X && k == K_CMP),
            (step == S_X && (k == K_MOVR || k == K_MVN)), 1'b0,
            (step == S_WI) ? 2'b01 : 2'b00, shf, alu,
            {{8{ir[7]}}, ir[7:0]}, {{11{ir[4]}}, ir[4:0]}};
  endfunction

  logic [15:0] m_ir;
  int          m_idx;
  int          m_len;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ir  <= 16'h0000;
      m_idx <= 0;
      m_len <= 0;
    end else if (m_idx >= m_len) begin
      m_ir <= bus.load ? bus.in : m_ir;
      if (bus.s) begin
        m_idx <= 0;
        m_len <= plan_len(bus.load ? bus.in : m_ir);
      end
    end else begin
      m_idx <= m_idx + 1;
    end
  end

  logic [51:0] dut_vec;
  assign dut_vec = {bus.w, bus.readnum, bus.writenum, bus.write, bus.loada, bus.loadb,
                    bus.loadc, bus.loads, bus.asel, bus.bsel, bus.vsel, bus.shift,
                    bus.ALUop, bus.sximm8, bus.sximm5};

  always @(negedge clk) begin
    if (rst_n && cmp_en)
      check("cycle outputs", 64'(dut_vec),
            64'(exp_vec((m_idx >= m_len) ? S_WAIT : plan_step(m_ir, m_idx), m_ir)));
  end

  // ---------------- directed stimulus ----------------
  logic [2:0]  r_readnum  [8];
  logic [2:0]  r_writenum [8];
  logic        r_write    [8];
  logic        r_loada    [8];
  logic        r_loadb    [8];
  logic        r_loadc    [8];
  logic        r_loads    [8];
  logic        r_asel     [8];
  logic [1:0]  r_vsel     [8];
  logic [1:0]  r_shift    [8];
  logic [1:0]  r_aluop    [8];
  logic [15:0] r_sximm8   [8];

  // Load a word, start it, record every busy cycle and check the busy length.
  task automatic run(input logic [15:0] word, input int exp_low, input string tag);
    int k;
    @(posedge clk); #1;
    bus.in = word; bus.load = 1'b1; bus.s = 1'b0;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.s = 1'b1;
    @(posedge clk); #1;
    bus.s = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (bus.w) break;
      if (k < 8) begin
        r_readnum[k] = bus.readnum;  r_writenum[k] = bus.writenum;
        r_write[k]   = bus.write;    r_loada[k]    = bus.loada;
        r_loadb[k]   = bus.loadb;    r_loadc[k]    = bus.loadc;
        r_loads[k]   = bus.loads;    r_asel[k]     = bus.asel;
        r_vsel[k]    = bus.vsel;     r_shift[k]    = bus.shift;
        r_aluop[k]   = bus.ALUop;    r_sximm8[k]   = bus.sximm8;
      end
      k++;
    end
    check({tag, " busy cycles"}, 64'(k), 64'(exp_low));
    $display("instr %h (%s): w low for %0d cycles", word, tag, k);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    bus.in = 16'h0000; bus.load = 1'b0; bus.s = 1'b0;
    #2;
    check("reset w", 64'(bus.w), 64'h1);
    check("reset write", 64'(bus.write), 64'h0);
    #10;
    rst_n = 1'b1;
    #1;
    check("post-reset sximm8", 64'(bus.sximm8), 64'h0);
    check("post-reset strobes", 64'({bus.loada, bus.loadb, bus.loadc, bus.loads}), 64'h0);
    cmp_en = 1'b1;

    run(16'hD007, 2, "MOV R0,#7");
    check("movi writenum", 64'(r_writenum[1]), 64'h0);
    check("movi write", 64'(r_write[1]), 64'h1);
    check("movi vsel", 64'(r_vsel[1]), 64'h1);
    check("movi sximm8", 64'(r_sximm8[1]), 64'h0007);

    run(16'hD1FE, 2, "MOV R1,#-2");
    check("movi neg sximm8", 64'(r_sximm8[1]), 64'hFFFE);
    check("movi neg writenum", 64'(r_writenum[1]), 64'h1);
    check("movi neg sximm5", 64'(bus.sximm5), 64'hFFFE);

    // load during DECODE must be ignored
    @(posedge clk); #1;
    bus.s = 1'b1;
    @(posedge clk); #1;
    bus.s = 1'b0; bus.in = 16'h1234; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    check("ir kept after decode load", 64'(bus.sximm8), 64'hFFFE);
    check("re-run writes R1", 64'(bus.writenum), 64'h1);
    @(posedge clk); #1;
    $display("instr d1fe re-run with load 1234 in DECODE");

    run(16'hA148, 5, "ADD R2,R1,R0,LSL#1");
    check("add geta readnum", 64'(r_readnum[1]), 64'h1);
    check("add geta loada", 64'(r_loada[1]), 64'h1);
    check("add getb readnum", 64'(r_readnum[2]), 64'h0);
    check("add getb shift", 64'(r_shift[2]), 64'h1);
    check("add exec loadc", 64'(r_loadc[3]), 64'h1);
    check("add exec aluop", 64'(r_aluop[3]), 64'h0);
    check("add write writenum", 64'(r_writenum[4]), 64'h2);
    check("add write", 64'(r_write[4]), 64'h1);

    run(16'hA801, 4, "CMP R0,R1");
    check("cmp no write", 64'(r_write[0] | r_write[1] | r_write[2] | r_write[3]), 64'h0);
    check("cmp loads only exec", 64'({r_loads[0], r_loads[1], r_loads[2], r_loads[3]}), 64'h1);
    check("cmp getb readnum", 64'(r_readnum[2]), 64'h1);

    run(16'hB860, 4, "MVN R3,R0");
    check("mvn exec asel", 64'(r_asel[2]), 64'h1);
    check("mvn exec aluop", 64'(r_aluop[2]), 64'h3);
    check("mvn writenum", 64'(r_writenum[3]), 64'h3);

    run(16'hC0B3, 4, "MOV R5,R3,LSR");
    check("movr exec asel", 64'(r_asel[2]), 64'h1);
    check("movr aluop", 64'(r_aluop[2]), 64'h0);
    check("movr shift", 64'(r_shift[1]), 64'h2);
    check("movr writenum", 64'(r_writenum[3]), 64'h5);

    run(16'hB29E, 5, "AND R4,R2,R6,ASR");
    check("and aluop", 64'(r_aluop[3]), 64'h2);

    run(16'h0000, 1, "illegal");
    check("illegal strobes", 64'({r_write[0], r_loada[0], r_loadb[0], r_loadc[0], r_loads[0]}), 64'h0);
    check("illegal addrs", 64'({r_readnum[0], r_writenum[0]}), 64'h0);

    // load and s on the same edge: the new word executes
    @(posedge clk); #1;
    bus.in = 16'hD007; bus.load = 1'b1; bus.s = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.s = 1'b0;
    check("same-edge load sximm8", 64'(bus.sximm8), 64'h0007);
    @(posedge clk); #1;
    check("same-edge load write", 64'(bus.write), 64'h1);
    $display("instr d007 loaded and started on the same edge");

    // held s restarts the same instruction
    @(posedge clk); #1;
    bus.s = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (!bus.w) cnt++;
    end
    bus.s = 1'b0;
    check("held s busy cycles", 64'(cnt), 64'h4);
    $display("instr d007 with s held: w low for %0d of 6 cycles", cnt);

    // reset during GET_B of an ADD
    @(posedge clk); #1;
    bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.s = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    check("pre-reset getb loadb", 64'(bus.loadb), 64'h1);
    rst_n = 1'b0;
    #1;
    check("async reset w", 64'(bus.w), 64'h1);
    check("async reset strobes", 64'({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}), 64'h0);
    check("async reset readnum", 64'(bus.readnum), 64'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ir cleared sximm8", 64'(bus.sximm8), 64'h0);
    check("ir cleared sximm5", 64'(bus.sximm5), 64'h0);
    $display("instr a148 aborted by reset in GET_B");

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
